uart_boot_loader: RTL and testbench

Consumes the byte stream from the UART receiver (data byte plus completion strobe). Parses a 4-byte little-endian word-count header, then assembles the following bytes into little-endian 32-bit words. Writes each word into instruction memory through a valid/ready write port, and reports done or error so the core can be released from reset.

---
 rtl/uart_loader_pkg.sv | 20 ++
 rtl/uart_word_assembler.sv | 51 +++++
 rtl/uart_boot_loader.sv | 140 ++++++++++++++
 tb/tb_uart_boot_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Imported by the word assembler and the loader FSM.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    HEADER,
    PAYLOAD,
    WRITE,
    DONE,
    ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LENGTH  = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_word_assembler.sv
// Turns the receiver strobe into single-cycle byte events and
// packs four consecutive bytes into a little-endian word.
module uart_word_assembler
  import uart_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic        byteStrobe,
  output logic        wordValid,
  output logic [1:0]  lane,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_LANE =
    2'(BYTES_PER_WORD - 1);

  logic        rxValidQ;
  logic [23:0] acc;

  always_ff @(posedge clock) begin
    if (reset) rxValidQ <= 1'b0;
    else       rxValidQ <= rxValid;
  end

  assign byteStrobe = rxValid && !rxValidQ;
  assign wordValid  = byteStrobe && take &&
                      (lane == LAST_LANE);
  // The top byte is taken straight from the bus so the
  // full word is usable on the edge of the 4th strobe.
  assign word = {rxData, acc};

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lane <= 2'd0;
      acc  <= '0;
    end else if (byteStrobe && take) begin
      lane <= lane + 2'd1;
      unique case (lane)
        2'd0: acc[7:0]   <= rxData;
        2'd1: acc[15:8]  <= rxData;
        2'd2: acc[23:16] <= rxData;
        2'd3: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Parses a length-prefixed byte stream from the UART and
// writes the payload words into instruction memory.
module uart_boot_loader
  import uart_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    MAX_WORDS      = 4096,
  parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rxData,
  input  logic                  rxValid,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWdata,
  output logic                  memWe,
  input  logic                  memReady,
  output logic [31:0]           wordCount,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            errorCode
);

  state_e      state, stateN;
  logic [1:0]  errN;
  logic        take, clear, accept, lastWord;
  logic        tout, counting;
  logic        byteStrobe, wordValid;
  logic [1:0]  lane;
  logic [31:0] word, length, wordIdx, tcnt;

  uart_word_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .take      (take),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .byteStrobe(byteStrobe),
    .wordValid (wordValid),
    .lane      (lane),
    .word      (word)
  );

  assign accept   = (state == WRITE) && memReady;
  assign lastWord = (wordIdx + 32'd1) == length;
  assign tout     = (tcnt == 32'(TIMEOUT_CYCLES - 1)) &&
                    !byteStrobe;
  assign counting = (state == PAYLOAD) ||
                    (state == HEADER && lane != 2'd0);
  assign clear    = (state == DONE) || (state == ERROR);

  always_comb begin
    stateN = state;
    errN   = errorCode;
    take   = 1'b0;
    unique case (state)
      HEADER: begin
        take = 1'b1;
        if (wordValid) begin
          if (word == 32'd0 ||
              word > 32'(MAX_WORDS)) begin
            stateN = ERROR;
            errN   = ERR_LENGTH;
          end else begin
            stateN = PAYLOAD;
          end
        end else if (lane != 2'd0 && tout) begin
          stateN = ERROR;
          errN   = ERR_TIMEOUT;
        end
      end
      PAYLOAD: begin
        take = 1'b1;
        if (wordValid) begin
          stateN = WRITE;
        end else if (tout) begin
          stateN = ERROR;
          errN   = ERR_TIMEOUT;
        end
      end
      WRITE: begin
        if (accept) begin
          // A strobe landing on the accept edge opens the next word.
          take   = !lastWord;
          stateN = lastWord ? DONE : PAYLOAD;
        end else if (byteStrobe) begin
          stateN = ERROR;
          errN   = ERR_OVERRUN;
        end
      end
      DONE:  ;
      ERROR: ;
      default: stateN = HEADER;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HEADER;
      errorCode <= ERR_NONE;
      length    <= '0;
      wordIdx   <= '0;
      wordCount <= '0;
      tcnt      <= '0;
      memAddr   <= '0;
      memWdata  <= '0;
    end else begin
      state     <= stateN;
      errorCode <= errN;
      if (byteStrobe || stateN != state)
        tcnt <= '0;
      else if (counting)
        tcnt <= tcnt + 32'd1;
      if (state == HEADER && wordValid) begin
        length  <= word;
        wordIdx <= '0;
      end
      if (state == PAYLOAD && wordValid) begin
        memWdata <= word;
        memAddr  <= BASE_ADDR +
          ADDR_WIDTH'({wordIdx[29:0], 2'b00});
      end
      if (accept) begin
        wordIdx   <= wordIdx + 32'd1;
        wordCount <= wordCount + 32'd1;
      end
    end
  end

  assign memWe = (state == WRITE);
  assign done  = (state == DONE);
  assign error = (state == ERROR);
  assign busy  = (state == PAYLOAD) ||
                 (state == WRITE) ||
                 (state == HEADER && lane != 2'd0);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected writes are
// queued as bytes are sent and matched on each accepted write.
module tb_uart_boot_loader;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rxData = 8'h00;
  logic        rxValid = 1'b0;
  logic        memReady = 1'b1;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memWe;
  logic [31:0] wordCount;
  logic        busy, done, error;
  logic [1:0]  errorCode;

  always #5 clock = ~clock;

  uart_boot_loader #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .memAddr  (memAddr),
    .memWdata (memWdata),
    .memWe    (memWe),
    .memReady (memReady),
    .wordCount(wordCount),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .errorCode(errorCode)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
  } wr_t;

  wr_t         sb[$];
  wr_t         e;
  int          checks = 0;
  int          errors = 0;
  int          weLen = 0;
  logic        unstable = 1'b0;
  logic [31:0] hAddr, hData;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (reset) begin
      weLen    = 0;
      unstable = 1'b0;
    end else if (memWe) begin
      if (weLen == 0) begin
        hAddr = memAddr;
        hData = memWdata;
      end else if (memAddr !== hAddr ||
                   memWdata !== hData) begin
        unstable = 1'b1;
      end
      weLen++;
      if (memReady) begin
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("wr_addr", memAddr, e.addr);
          check("wr_data", memWdata, e.data);
          check("wr_len", weLen, e.len);
          check("wr_stable", 32'(unstable), 0);
        end
        weLen    = 0;
        unstable = 1'b0;
      end
    end else begin
      weLen    = 0;
      unstable = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int w = 1);
    rxData  = b;
    rxValid = 1'b1;
    idle(w);
    rxValid = 1'b0;
    idle(1);
  endtask

  task automatic send_word(input logic [31:0] v);
    send_byte(v[7:0]);
    send_byte(v[15:8]);
    send_byte(v[23:16]);
    send_byte(v[31:24]);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rxValid  = 1'b0;
    memReady = 1'b1;
    idle(2);
    reset = 1'b0;
    check("rst_ctl",
          {memWe, done, error, busy, errorCode}, 0);
    check("rst_count", wordCount, 0);
    check("rst_addr", memAddr, 0);
    check("rst_wdata", memWdata, 0);
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done || error) break;
      idle(1);
    end
    check("wait_end", 32'(done | error), 1);
  endtask

  initial begin
    idle(1);
    do_reset();

    // nominal two-word frame
    sb.push_back('{32'h0, 32'h1234_5678, 1});
    sb.push_back('{32'h4, 32'hDEAD_BEEF, 1});
    send_byte(8'h02);
    check("busy_hdr", busy, 1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    wait_end(20);
    check("nom_done", done, 1);
    check("nom_count", wordCount, 2);
    check("nom_busy", busy, 0);
    check("nom_err", error, 0);
    check("nom_sb", sb.size(), 0);

    // write stalled for 10 cycles
    do_reset();
    sb.push_back('{32'h0, 32'hA1B2_C3D4, 11});
    send_word(32'd1);
    memReady = 1'b0;
    send_word(32'hA1B2_C3D4);
    for (int i = 0; i < 40; i++) begin
      if (weLen >= 10) break;
      idle(1);
    end
    check("stall_len", weLen, 10);
    memReady = 1'b1;
    wait_end(10);
    check("stall_count", wordCount, 1);
    check("stall_done", done, 1);

    // bad lengths and the largest legal length
    do_reset();
    send_word(32'd0);
    idle(2);
    check("len0_err", error, 1);
    check("len0_code", errorCode, 1);
    check("len0_busy", busy, 0);
    do_reset();
    send_word(32'h1001);
    idle(2);
    check("lenmax1_code", errorCode, 1);
    do_reset();
    send_word(32'h1000);
    check("lenmax_err", error, 0);
    check("lenmax_busy", busy, 1);

    // overrun while a write is pending
    do_reset();
    memReady = 1'b0;
    send_word(32'd2);
    send_word(32'h4433_2211);
    check("ovr_we_pre", memWe, 1);
    send_byte(8'h55);
    check("ovr_we", memWe, 0);
    check("ovr_code", errorCode, 2);
    check("ovr_count", wordCount, 0);
    memReady = 1'b1;
    send_word(32'h0102_0304);
    check("ovr_hold", errorCode, 2);
    check("ovr_count2", wordCount, 0);
    check("ovr_done", done, 0);

    // gap just under the timeout is tolerated
    do_reset();
    sb.push_back('{32'h0, 32'hCAFE_F00D, 1});
    send_word(32'd1);
    send_byte(8'h0D);
    idle(TO - 3);
    send_byte(8'hF0);
    send_byte(8'hFE);
    send_byte(8'hCA);
    wait_end(10);
    check("gap_done", done, 1);
    check("gap_err", error, 0);

    // stall mid-payload until the timeout fires
    do_reset();
    send_word(32'd1);
    send_byte(8'hAA);
    idle(TO - 4);
    check("to_early", error, 0);
    idle(4);
    check("to_err", error, 1);
    check("to_code", errorCode, 3);

    // idle line before the header never times out
    do_reset();
    idle(3 * TO);
    check("idle_err", error, 0);
    check("idle_busy", busy, 0);

    // wide strobe counts as a single byte
    do_reset();
    sb.push_back('{32'h0, 32'h0BAD_F00D, 1});
    send_byte(8'h01, 5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h0BAD_F00D);
    wait_end(10);
    check("wide_done", done, 1);
    check("wide_count", wordCount, 1);

    // reset mid-payload, then a fresh frame
    do_reset();
    send_word(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset();
    sb.push_back('{32'h0, 32'h8765_4321, 1});
    send_word(32'd1);
    send_word(32'h8765_4321);
    wait_end(10);
    check("mrst_done", done, 1);
    check("mrst_count", wordCount, 1);
    check("end_sb", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
